tone_param_bank: RTL and testbench

//  Downstream of the AXIS command decoder. Holds the shadow and active index/gain registers for 2 channels x N_TONE tones.

---
 rtl/tone_param_bank_pkg.sv | 25 ++
 rtl/tone_param_bank_if.sv | 42 ++++
 rtl/tone_param_bank_chan_regs.sv | 59 +++++
 rtl/tone_param_bank.sv | 138 +++++++++++++
 tb/tb_tone_param_bank.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_param_bank_pkg.sv
// Shared definitions for the tone parameter bank: default widths, tone limits,
// decoder command codes and the commit FSM encoding.
package tone_param_bank_pkg;

  localparam int IDX_W_DEF  = 10;
  localparam int GAIN_W_DEF = 18;
  localparam int N_TONE_MAX = 8;

  // Command codes produced by the upstream AXIS decoder
  localparam logic [3:0] CMD_IDX    = 4'h1;
  localparam logic [3:0] CMD_GAIN   = 4'h2;
  localparam logic [3:0] CMD_COMMIT = 4'h3;
  localparam logic [3:0] CMD_SAFE   = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_APPLY     = 2'd2
  } state_t;

  function automatic logic tone_valid(input logic [2:0] tone, input int n_tone);
    return ({1'b0, tone} < 4'(n_tone));
  endfunction

endpackage

// File: rtl/tone_param_bank_if.sv
// Bus between the command decoder / DDS side and the tone parameter bank.
// master drives writes, commits, SAFE and frame_sync; slave returns active values and status.
interface tone_param_bank_if #(
  parameter int IDX_W  = tone_param_bank_pkg::IDX_W_DEF,
  parameter int GAIN_W = tone_param_bank_pkg::GAIN_W_DEF,
  parameter int N_TONE = tone_param_bank_pkg::N_TONE_MAX
);
  logic                     idx_we;
  logic                     gain_we;
  logic                     wr_ch;
  logic [2:0]               wr_tone;
  logic [IDX_W-1:0]         wr_index;
  logic [GAIN_W-1:0]        wr_gain;
  logic                     commit_req;
  logic                     safe_we;
  logic                     safe_val;
  logic                     frame_sync;
  logic [N_TONE*IDX_W-1:0]  act_index_a;
  logic [N_TONE*IDX_W-1:0]  act_index_b;
  logic [N_TONE*GAIN_W-1:0] act_gain_a;
  logic [N_TONE*GAIN_W-1:0] act_gain_b;
  logic                     commit_done;
  logic                     commit_blocked;
  logic                     commit_busy;
  logic                     shadow_dirty;
  logic                     safe_en;

  modport master (
    output idx_we, gain_we, wr_ch, wr_tone, wr_index, wr_gain,
    output commit_req, safe_we, safe_val, frame_sync,
    input  act_index_a, act_index_b, act_gain_a, act_gain_b,
    input  commit_done, commit_blocked, commit_busy, shadow_dirty, safe_en
  );

  modport slave (
    input  idx_we, gain_we, wr_ch, wr_tone, wr_index, wr_gain,
    input  commit_req, safe_we, safe_val, frame_sync,
    output act_index_a, act_index_b, act_gain_a, act_gain_b,
    output commit_done, commit_blocked, commit_busy, shadow_dirty, safe_en
  );

endinterface

// File: rtl/tone_param_bank_chan_regs.sv
// One channel of tone parameters: shadow index/gain per tone, write decode,
// and the active copy loaded from shadow in a single cycle on copy_en.
module tone_chan_regs
  import tone_param_bank_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int N_TONE = N_TONE_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idx_we,
  input  logic                     gain_we,
  input  logic [2:0]               wr_tone,
  input  logic [IDX_W-1:0]         wr_index,
  input  logic [GAIN_W-1:0]        wr_gain,
  input  logic                     copy_en,
  output logic [N_TONE*IDX_W-1:0]  act_index,
  output logic [N_TONE*GAIN_W-1:0] act_gain
);

  logic [IDX_W-1:0]  shd_index_r [N_TONE];
  logic [GAIN_W-1:0] shd_gain_r  [N_TONE];
  logic [N_TONE-1:0] sel_s;

  // One-hot tone select; a tone number at or beyond N_TONE selects nothing
  always_comb begin
    sel_s = '0;
    for (int t = 0; t < N_TONE; t++) begin
      sel_s[t] = (wr_tone == 3'(t));
    end
  end

  // Shadow writes and bulk copy; the copy samples shadow before a same-edge write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_TONE; t++) begin
        shd_index_r[t] <= '0;
        shd_gain_r[t]  <= '0;
      end
      act_index <= '0;
      act_gain  <= '0;
    end else begin
      for (int t = 0; t < N_TONE; t++) begin
        if (idx_we && sel_s[t]) begin
          shd_index_r[t] <= wr_index;
        end
        if (gain_we && sel_s[t]) begin
          shd_gain_r[t] <= wr_gain;
        end
        if (copy_en) begin
          act_index[t*IDX_W +: IDX_W]   <= shd_index_r[t];
          act_gain[t*GAIN_W +: GAIN_W]  <= shd_gain_r[t];
        end
      end
    end
  end

endmodule

// File: rtl/tone_param_bank.sv
// Shadow/active tone parameter bank for two channels with a SAFE-gated commit FSM
// that copies all shadow registers to active either immediately or at frame_sync.
module tone_param_bank
  import tone_param_bank_pkg::*;
#(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int GAIN_W   = GAIN_W_DEF,
  parameter int N_TONE   = N_TONE_MAX,
  parameter int USE_SYNC = 1
) (
  input logic              clk,
  input logic              rst,
  tone_param_bank_if.slave bus
);

  state_t state_r;
  state_t state_next_s;
  logic   blocked_next_s;
  logic   apply_s;
  logic   write_ok_s;
  logic   safe_en_r;
  logic   dirty_r;
  logic   done_r;
  logic   blocked_r;
  logic   busy_r;
  logic   we_idx_a_s;
  logic   we_idx_b_s;
  logic   we_gain_a_s;
  logic   we_gain_b_s;

  assign apply_s     = (state_r == ST_APPLY);
  assign write_ok_s  = (bus.idx_we | bus.gain_we) & tone_valid(bus.wr_tone, N_TONE);
  assign we_idx_a_s  = bus.idx_we  & (bus.wr_ch == 1'b0);
  assign we_idx_b_s  = bus.idx_we  & (bus.wr_ch == 1'b1);
  assign we_gain_a_s = bus.gain_we & (bus.wr_ch == 1'b0);
  assign we_gain_b_s = bus.gain_we & (bus.wr_ch == 1'b1);

  // Commit FSM next state; a SAFE drop while waiting wins over a coincident frame_sync
  always_comb begin
    state_next_s   = state_r;
    blocked_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.commit_req) begin
          if (safe_en_r) begin
            state_next_s = (USE_SYNC != 0) ? ST_WAIT_SYNC : ST_APPLY;
          end else begin
            blocked_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (bus.safe_we && !bus.safe_val) begin
          state_next_s   = ST_IDLE;
          blocked_next_s = 1'b1;
        end else if (bus.frame_sync) begin
          state_next_s = ST_APPLY;
        end else begin
          state_next_s = ST_WAIT_SYNC;
        end
      end
      ST_APPLY: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, SAFE flag, dirty tracking and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      safe_en_r <= 1'b0;
      dirty_r   <= 1'b0;
      done_r    <= 1'b0;
      blocked_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
      done_r    <= apply_s;
      blocked_r <= blocked_next_s;
      if (bus.safe_we) begin
        safe_en_r <= bus.safe_val;
      end
      if (write_ok_s) begin
        dirty_r <= 1'b1;
      end else if (apply_s) begin
        dirty_r <= 1'b0;
      end
    end
  end

  tone_chan_regs #(
    .IDX_W  (IDX_W),
    .GAIN_W (GAIN_W),
    .N_TONE (N_TONE)
  ) u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .idx_we    (we_idx_a_s),
    .gain_we   (we_gain_a_s),
    .wr_tone   (bus.wr_tone),
    .wr_index  (bus.wr_index),
    .wr_gain   (bus.wr_gain),
    .copy_en   (apply_s),
    .act_index (bus.act_index_a),
    .act_gain  (bus.act_gain_a)
  );

  tone_chan_regs #(
    .IDX_W  (IDX_W),
    .GAIN_W (GAIN_W),
    .N_TONE (N_TONE)
  ) u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .idx_we    (we_idx_b_s),
    .gain_we   (we_gain_b_s),
    .wr_tone   (bus.wr_tone),
    .wr_index  (bus.wr_index),
    .wr_gain   (bus.wr_gain),
    .copy_en   (apply_s),
    .act_index (bus.act_index_b),
    .act_gain  (bus.act_gain_b)
  );

  assign bus.commit_done    = done_r;
  assign bus.commit_blocked = blocked_r;
  assign bus.commit_busy    = busy_r;
  assign bus.shadow_dirty   = dirty_r;
  assign bus.safe_en        = safe_en_r;

endmodule

// File: tb/tb_tone_param_bank.sv
// Scoreboard bench: dut_i (immediate commit, 8 tones) and dut_s (frame-synced, 4 tones).
// Expected commit_done/commit_blocked events are queued at stimulus time and popped by a monitor.
`timescale 1ns/1ps
module tb_tone_param_bank;

  localparam int IW   = 10;
  localparam int GW   = 18;
  localparam int NT_I = 8;
  localparam int NT_S = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  tone_param_bank_if #(.IDX_W(IW), .GAIN_W(GW), .N_TONE(NT_I)) bus_i ();
  tone_param_bank_if #(.IDX_W(IW), .GAIN_W(GW), .N_TONE(NT_S)) bus_s ();

  tone_param_bank #(.IDX_W(IW), .GAIN_W(GW), .N_TONE(NT_I), .USE_SYNC(0)) dut_i (
    .clk(clk), .rst(rst), .bus(bus_i.slave));
  tone_param_bank #(.IDX_W(IW), .GAIN_W(GW), .N_TONE(NT_S), .USE_SYNC(1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave));

  logic          tgt;
  logic          idx_we, gain_we, wr_ch, commit_req, safe_we, safe_val, frame_sync;
  logic [2:0]    wr_tone;
  logic [IW-1:0] wr_index;
  logic [GW-1:0] wr_gain;

  assign bus_i.idx_we     = idx_we & ~tgt;
  assign bus_i.gain_we    = gain_we & ~tgt;
  assign bus_i.commit_req = commit_req & ~tgt;
  assign bus_i.safe_we    = safe_we & ~tgt;
  assign bus_i.frame_sync = frame_sync & ~tgt;
  assign bus_i.wr_ch      = wr_ch;
  assign bus_i.wr_tone    = wr_tone;
  assign bus_i.wr_index   = wr_index;
  assign bus_i.wr_gain    = wr_gain;
  assign bus_i.safe_val   = safe_val;
  assign bus_s.idx_we     = idx_we & tgt;
  assign bus_s.gain_we    = gain_we & tgt;
  assign bus_s.commit_req = commit_req & tgt;
  assign bus_s.safe_we    = safe_we & tgt;
  assign bus_s.frame_sync = frame_sync & tgt;
  assign bus_s.wr_ch      = wr_ch;
  assign bus_s.wr_tone    = wr_tone;
  assign bus_s.wr_index   = wr_index;
  assign bus_s.wr_gain    = wr_gain;
  assign bus_s.safe_val   = safe_val;

  typedef struct {
    bit               blocked;
    int               at;
    logic [8*IW-1:0]  ia;
    logic [8*IW-1:0]  ib;
    logic [8*GW-1:0]  ga;
    logic [8*GW-1:0]  gb;
  } ev_t;

  ev_t q_i[$];
  ev_t q_s[$];

  logic [8*IW-1:0] exp_ia, exp_ib;
  logic [8*GW-1:0] exp_ga, exp_gb;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    chk(name, 512'(act), 512'(expv));
  endtask

  task automatic push(input bit which, input bit blk, input int at);
    ev_t e;
    e.blocked = blk;
    e.at      = at;
    e.ia      = exp_ia;
    e.ib      = exp_ib;
    e.ga      = exp_ga;
    e.gb      = exp_gb;
    if (which) q_s.push_back(e);
    else       q_i.push_back(e);
  endtask

  task automatic mon(input bit which, input logic done, input logic blocked,
                     input logic [8*IW-1:0] ia, input logic [8*IW-1:0] ib,
                     input logic [8*GW-1:0] ga, input logic [8*GW-1:0] gb);
    ev_t e;
    if ((which && q_s.size() == 0) || (!which && q_i.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse dut%0d: done=%0b blocked=%0b at cycle %0d, required no pulse",
               which, done, blocked, cyc);
      return;
    end
    e = which ? q_s.pop_front() : q_i.pop_front();
    chk("ev_kind", 512'({done, blocked}), 512'(e.blocked ? 2'b01 : 2'b10));
    chk("ev_cycle", 512'(cyc), 512'(e.at));
    chk("ev_index", 512'({ia, ib}), 512'({e.ia, e.ib}));
    chk("ev_gain", 512'({ga, gb}), 512'({e.ga, e.gb}));
  endtask

  // Monitor: every status pulse must match the head of that DUT's expectation queue
  always @(negedge clk) begin
    if (bus_i.commit_done || bus_i.commit_blocked)
      mon(1'b0, bus_i.commit_done, bus_i.commit_blocked,
          bus_i.act_index_a, bus_i.act_index_b, bus_i.act_gain_a, bus_i.act_gain_b);
    if (bus_s.commit_done || bus_s.commit_blocked)
      mon(1'b1, bus_s.commit_done, bus_s.commit_blocked,
          80'(bus_s.act_index_a), 80'(bus_s.act_index_b),
          144'(bus_s.act_gain_a), 144'(bus_s.act_gain_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    idx_we = 1'b0; gain_we = 1'b0; commit_req = 1'b0; safe_we = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic wr(input logic ch, input logic [2:0] tone, input logic iw, input logic gw,
                    input logic [IW-1:0] ix, input logic [GW-1:0] g);
    wr_ch = ch; wr_tone = tone; idx_we = iw; gain_we = gw; wr_index = ix; wr_gain = g;
    tick();
    idle_in();
  endtask

  task automatic set_safe(input logic v);
    safe_we = 1'b1; safe_val = v;
    tick();
    idle_in();
  endtask

  task automatic chk_act_s(input string name);
    chk(name, 512'({bus_s.act_index_a, bus_s.act_index_b, bus_s.act_gain_a, bus_s.act_gain_b}),
        512'({exp_ia[4*IW-1:0], exp_ib[4*IW-1:0], exp_ga[4*GW-1:0], exp_gb[4*GW-1:0]}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required end of test", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tgt = 1'b0; idle_in();
    wr_ch = 1'b0; wr_tone = 3'd0; wr_index = '0; wr_gain = '0; safe_val = 1'b0;
    exp_ia = '0; exp_ib = '0; exp_ga = '0; exp_gb = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state, then a commit with SAFE low is refused for one cycle
    chk("rst_act_i", 512'({bus_i.act_index_a, bus_i.act_index_b, bus_i.act_gain_a, bus_i.act_gain_b}), 512'(0));
    chk("rst_flags_i", 512'({bus_i.safe_en, bus_i.commit_busy, bus_i.shadow_dirty,
                             bus_i.commit_done, bus_i.commit_blocked}), 512'(0));
    chk_act_s("rst_act_s");
    chk("rst_flags_s", 512'({bus_s.safe_en, bus_s.commit_busy, bus_s.shadow_dirty}), 512'(0));
    commit_req = 1'b1;
    push(1'b0, 1'b1, cyc + 1);
    tick(); idle_in();
    tick();
    chk1("blocked_one_cycle", bus_i.commit_blocked, 1'b0);
    chk1("blocked_not_busy", bus_i.commit_busy, 1'b0);

    // 2: immediate commit on dut_i, N+2 latency, merged request during APPLY
    set_safe(1'b1);
    chk1("safe_en_i", bus_i.safe_en, 1'b1);
    wr(1'b0, 3'd3, 1'b1, 1'b0, 10'h155, 18'h0);
    wr(1'b1, 3'd7, 1'b0, 1'b1, 10'h0, 18'h1FFFF);
    wr(1'b1, 3'd0, 1'b1, 1'b1, 10'h2AA, 18'h20001);
    chk1("dirty_after_write_i", bus_i.shadow_dirty, 1'b1);
    chk("act_before_commit_i", 512'(bus_i.act_index_a), 512'(0));
    exp_ia[30 +: IW]  = 10'h155;
    exp_ib[0 +: IW]   = 10'h2AA;
    exp_gb[126 +: GW] = 18'h1FFFF;
    exp_gb[0 +: GW]   = 18'h20001;
    commit_req = 1'b1;
    push(1'b0, 1'b0, cyc + 2);
    tick();
    chk1("busy_in_apply_i", bus_i.commit_busy, 1'b1);
    tick(); idle_in();
    chk("act_a_tone3_i", 512'(bus_i.act_index_a[39:30]), 512'(10'h155));
    chk1("dirty_cleared_i", bus_i.shadow_dirty, 1'b0);
    chk1("idle_after_apply_i", bus_i.commit_busy, 1'b0);
    tick();
    chk1("done_one_cycle_i", bus_i.commit_done, 1'b0);

    // 3: frame-synced commit on dut_s with an ignored out-of-range write first
    tgt = 1'b1;
    exp_ia = '0; exp_ib = '0; exp_ga = '0; exp_gb = '0;
    set_safe(1'b1);
    chk1("safe_en_s", bus_s.safe_en, 1'b1);
    wr(1'b0, 3'd7, 1'b1, 1'b1, 10'h3FF, 18'h3FFFF);
    chk1("ignored_write_not_dirty", bus_s.shadow_dirty, 1'b0);
    wr(1'b0, 3'd1, 1'b1, 1'b1, 10'h0AB, 18'h12345);
    wr(1'b1, 3'd3, 1'b0, 1'b1, 10'h0, 18'h3FFFF);
    commit_req = 1'b1; frame_sync = 1'b1;
    tick(); idle_in();
    for (int i = 0; i < 20; i++) begin
      chk1("busy_waiting_s", bus_s.commit_busy, 1'b1);
      chk_act_s("act_stable_waiting_s");
      commit_req = (i == 5);
      tick(); idle_in();
    end
    exp_ia[10 +: IW] = 10'h0AB;
    exp_ga[18 +: GW] = 18'h12345;
    exp_gb[54 +: GW] = 18'h3FFFF;
    frame_sync = 1'b1;
    push(1'b1, 1'b0, cyc + 2);
    tick(); idle_in();
    tick();
    chk1("dirty_cleared_s", bus_s.shadow_dirty, 1'b0);
    chk1("idle_after_apply_s", bus_s.commit_busy, 1'b0);

    // 4: SAFE drop coincident with frame_sync cancels the pending commit
    wr(1'b0, 3'd2, 1'b1, 1'b0, 10'h111, 18'h0);
    commit_req = 1'b1;
    tick(); idle_in();
    chk1("busy_before_cancel_s", bus_s.commit_busy, 1'b1);
    safe_we = 1'b1; safe_val = 1'b0; frame_sync = 1'b1;
    push(1'b1, 1'b1, cyc + 1);
    tick(); idle_in();
    chk1("cancel_to_idle_s", bus_s.commit_busy, 1'b0);
    chk1("cancel_safe_low_s", bus_s.safe_en, 1'b0);
    repeat (3) tick();
    chk_act_s("act_unchanged_after_cancel_s");
    chk1("dirty_kept_after_cancel_s", bus_s.shadow_dirty, 1'b1);

    // 5: write landing in the APPLY cycle stays in shadow only
    set_safe(1'b1);
    wr(1'b0, 3'd0, 1'b1, 1'b0, 10'h200, 18'h0);
    commit_req = 1'b1;
    tick(); idle_in();
    tick();
    exp_ia[0 +: IW]  = 10'h200;
    exp_ia[20 +: IW] = 10'h111;
    frame_sync = 1'b1;
    push(1'b1, 1'b0, cyc + 2);
    tick(); idle_in();
    wr(1'b0, 3'd0, 1'b1, 1'b0, 10'h3FF, 18'h0);
    chk("apply_took_old_value_s", 512'(bus_s.act_index_a[9:0]), 512'(10'h200));
    chk1("dirty_kept_apply_write_s", bus_s.shadow_dirty, 1'b1);
    commit_req = 1'b1;
    tick(); idle_in();
    exp_ia[0 +: IW] = 10'h3FF;
    frame_sync = 1'b1;
    push(1'b1, 1'b0, cyc + 2);
    tick(); idle_in();
    tick();
    chk1("dirty_cleared_second_s", bus_s.shadow_dirty, 1'b0);

    // 6: reset while waiting for frame_sync aborts the commit
    wr(1'b1, 3'd2, 1'b1, 1'b1, 10'h0F0, 18'h0F0F0);
    commit_req = 1'b1;
    tick(); idle_in();
    chk1("busy_before_reset_s", bus_s.commit_busy, 1'b1);
    rst = 1'b1;
    #1;
    exp_ia = '0; exp_ib = '0; exp_ga = '0; exp_gb = '0;
    chk_act_s("act_zero_in_reset_s");
    chk("flags_zero_in_reset_s", 512'({bus_s.safe_en, bus_s.commit_busy, bus_s.shadow_dirty,
                                       bus_s.commit_done, bus_s.commit_blocked}), 512'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    frame_sync = 1'b1;
    tick(); idle_in();
    tick();
    chk1("no_done_after_reset_s", bus_s.commit_done, 1'b0);
    chk1("idle_after_reset_s", bus_s.commit_busy, 1'b0);
    repeat (2) tick();

    chk("pending_events", 512'(q_i.size() + q_s.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
